// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order bus requests, buffers returned words
// for decode, and drops responses that belong to requests issued before a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus
);
    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTST);
    localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
    localparam logic [QW-1:0] PLAST   = QW'(MAX_OUTST - 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          halted_q, halted_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [CW-1:0] ibuf_cnt_q, ibuf_cnt_d;
    logic [PW-1:0] ibuf_rd_q, ibuf_rd_d;
    logic [PW-1:0] ibuf_wr_q, ibuf_wr_d;
    logic [QW-1:0] pend_rd_q, pend_rd_d;
    logic [QW-1:0] pend_wr_q, pend_wr_d;
    logic [64:0]   ibuf_q [IBUF_DEPTH];
    logic [31:0]   pend_q [MAX_OUTST];

    logic          redirect;
    logic [31:0]   redir_tgt;
    logic          misaligned;
    logic [OW-1:0] live_outst;
    logic          room;
    logic          hs;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          adef_push;
    logic          ibuf_push;
    logic          ibuf_pop;
    logic [64:0]   push_entry;

    function automatic logic [QW-1:0] pnext(input logic [QW-1:0] p);
        return (p == PLAST) ? '0 : p + QW'(1);
    endfunction

    assign redirect   = flush_valid | br_valid;
    assign redir_tgt  = flush_valid ? flush_target : br_target;
    assign misaligned = fetch_pc_q[1:0] != 2'b00;
    assign live_outst = outst_q - discard_q;
    // Every live request must already own a buffer slot, so the buffer cannot overflow.
    assign room       = (32'(live_outst) + 32'(ibuf_cnt_q)) < IBUF_DEPTH;

    assign inst_req   = resetn & ~misaligned & ~redirect & ~halted_q & (outst_q < MAX_O) & room;
    assign inst_addr  = resetn ? fetch_pc_q : RESET_PC;
    assign hs         = inst_req & inst_addr_ok;

    assign rsp_drop   = inst_data_ok & (discard_q != '0);
    assign rsp_keep   = inst_data_ok & (discard_q == '0);
    assign adef_push  = resetn & misaligned & ~halted_q & ~redirect
                      & (live_outst == '0) & (ibuf_cnt_q != DEPTH_C);
    assign ibuf_push  = (rsp_keep | adef_push) & ~redirect;
    assign ibuf_pop   = fs_to_ds_valid & ds_allowin & ~redirect;
    assign push_entry = adef_push ? {1'b1, 32'h0, fetch_pc_q}
                                  : {1'b0, inst_rdata, pend_q[pend_rd_q]};

    assign fs_to_ds_valid = resetn & (ibuf_cnt_q != '0);
    assign fs_to_ds_bus   = ibuf_q[ibuf_rd_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        outst_d    = outst_q + OW'(hs) - OW'(inst_data_ok);
        discard_d  = discard_q;
        ibuf_cnt_d = ibuf_cnt_q;
        ibuf_rd_d  = ibuf_rd_q;
        ibuf_wr_d  = ibuf_wr_q;
        pend_rd_d  = pend_rd_q;
        pend_wr_d  = pend_wr_q;
        if (redirect) begin
            // A response landing this cycle is already stale, hence the subtraction.
            fetch_pc_d = redir_tgt;
            halted_d   = 1'b0;
            discard_d  = outst_q - OW'(inst_data_ok);
            ibuf_cnt_d = '0;
            ibuf_rd_d  = '0;
            ibuf_wr_d  = '0;
            pend_rd_d  = '0;
            pend_wr_d  = '0;
        end else begin
            if (hs) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pend_wr_d  = pnext(pend_wr_q);
            end
            if (adef_push) halted_d = 1'b1;
            if (rsp_drop)  discard_d = discard_q - OW'(1);
            if (rsp_keep)  pend_rd_d = pnext(pend_rd_q);
            if (ibuf_push) ibuf_wr_d = ibuf_wr_q + PW'(1);
            if (ibuf_pop)  ibuf_rd_d = ibuf_rd_q + PW'(1);
            ibuf_cnt_d = ibuf_cnt_q + CW'(ibuf_push) - CW'(ibuf_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            outst_q    <= '0;
            discard_q  <= '0;
            ibuf_cnt_q <= '0;
            ibuf_rd_q  <= '0;
            ibuf_wr_q  <= '0;
            pend_rd_q  <= '0;
            pend_wr_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            ibuf_cnt_q <= ibuf_cnt_d;
            ibuf_rd_q  <= ibuf_rd_d;
            ibuf_wr_q  <= ibuf_wr_d;
            pend_rd_q  <= pend_rd_d;
            pend_wr_q  <= pend_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ibuf_push) ibuf_q[ibuf_wr_q] <= push_entry;
        if (hs)        pend_q[pend_wr_q] <= fetch_pc_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order bus slave with random latency plus a reference model of
// the instruction stream decode should see (sequential PCs from each redirect target).
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_target = '0;
    logic        ds_allowin = 1'b0;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .IBUF_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .br_valid(br_valid), .br_target(br_target),
        .flush_valid(flush_valid), .flush_target(flush_target),
        .ds_allowin(ds_allowin),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } rsp_t;
    rsp_t resp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ok_pct = 100;
    int rsp_pct = 100;
    int lat_max = 0;
    int deliv_cnt = 0;

    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    bit          exp_done;
    bit          tgt_bad;
    bit          prev_stall;
    bit          prev_redir;
    logic [31:0] prev_addr;
    bit          last_deliv;
    bit          last_req;
    logic [64:0] last_bus;
    bit          want_first;
    logic [64:0] first_bus;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive slave/handshake inputs, compare against the model mid-cycle, advance.
    task automatic step();
        bit          redir;
        bit          hs;
        bit          dok;
        bit          deliv;
        logic [31:0] tgt;
        inst_addr_ok = ($urandom_range(99) < ok_pct);
        dok = 1'b0;
        if (resetn && resp_q.size() > 0)
            if (resp_q[0].rdy <= cyc && $urandom_range(99) < rsp_pct) dok = 1'b1;
        inst_data_ok = dok;
        inst_rdata   = dok ? memf(resp_q[0].addr) : $urandom;
        #2;
        redir = resetn && (flush_valid || br_valid);
        tgt   = flush_valid ? flush_target : br_target;
        hs    = inst_req && inst_addr_ok;
        deliv = fs_to_ds_valid && ds_allowin && !redir;
        last_req   = inst_req;
        last_deliv = deliv;
        last_bus   = fs_to_ds_bus;
        if (inst_req) chk("addr_align", 65'(inst_addr[1:0]), 65'(0));
        if (redir) chk("req_in_redirect", 65'(inst_req), 65'(0));
        if (tgt_bad && resetn) chk("req_when_halted", 65'(inst_req), 65'(0));
        if (prev_stall && resetn && !redir) begin
            chk("req_stable", 65'(inst_req), 65'(1));
            chk("addr_stable", 65'(inst_addr), 65'(prev_addr));
        end
        if (prev_redir) chk("valid_after_redirect", 65'(fs_to_ds_valid), 65'(0));
        if (hs) begin
            chk("fetch_addr", 65'(inst_addr), 65'(exp_fetch));
            resp_q.push_back('{addr: inst_addr, rdy: cyc + 1 + $urandom_range(lat_max)});
            exp_fetch += 32'd4;
        end
        if (dok) resp_q.delete(0);
        chk("outstanding", 65'(resp_q.size() <= MAXO), 65'(1));
        if (deliv) begin
            deliv_cnt++;
            if (want_first) begin
                first_bus  = fs_to_ds_bus;
                want_first = 1'b0;
            end
            if (exp_done) chk("extra_entry", 65'(fs_to_ds_valid), 65'(0));
            else if (exp_pc[1:0] != 2'b00) begin
                chk("adef_entry", fs_to_ds_bus, {1'b1, 32'h0, exp_pc});
                exp_done = 1'b1;
            end else begin
                chk("entry", fs_to_ds_bus, {1'b0, memf(exp_pc), exp_pc});
                exp_pc += 32'd4;
            end
        end
        if (redir) begin
            exp_fetch  = tgt;
            exp_pc     = tgt;
            exp_done   = 1'b0;
            tgt_bad    = (tgt[1:0] != 2'b00);
            want_first = 1'b1;
        end
        prev_stall = resetn && inst_req && !inst_addr_ok;
        prev_addr  = inst_addr;
        prev_redir = redir;
        @(posedge clk);
        #1;
        cyc++;
        br_valid    = 1'b0;
        flush_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        br_valid    = 1'b0;
        flush_valid = 1'b0;
        resp_q.delete();
        exp_fetch  = RESET_PC;
        exp_pc     = RESET_PC;
        exp_done   = 1'b0;
        tgt_bad    = 1'b0;
        want_first = 1'b1;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        step();
        step();
        chk("rst_req", 65'(inst_req), 65'(0));
        chk("rst_valid", 65'(fs_to_ds_valid), 65'(0));
        chk("rst_addr", 65'(inst_addr), 65'(RESET_PC));
        resetn = 1'b1;
    endtask

    task automatic wait_first(input string tag);
        for (int i = 0; i < 40 && want_first; i++) step();
        chk(tag, 65'(want_first), 65'(0));
    endtask

    initial begin
        #1;
        do_reset();

        // Streaming at one instruction per cycle with immediate responses.
        ok_pct = 100; rsp_pct = 100; lat_max = 0; ds_allowin = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("tput_valid", 65'(last_deliv), 65'(1));
            chk("tput_pc", 65'(last_bus[31:0]), 65'(RESET_PC + 32'(4 * k)));
            chk("tput_adef", 65'(last_bus[64]), 65'(0));
        end

        // Decode stalled: buffer fills to exactly DEPTH and requests stop.
        ds_allowin = 1'b0;
        repeat (20) step();
        chk("full_no_req", 65'(last_req), 65'(0));
        ok_pct = 0;
        ds_allowin = 1'b1;
        deliv_cnt = 0;
        repeat (8) step();
        chk("full_count", 65'(deliv_cnt), 65'(DEPTH));

        // addr_ok was withheld above with inst_req up; resume and confirm the handshake.
        ok_pct = 100;
        step();
        chk("resume_req", 65'(last_req), 65'(1));
        repeat (4) step();

        // Branch with two requests in flight: both responses are dropped.
        rsp_pct = 0;
        for (int i = 0; i < 10 && resp_q.size() < 2; i++) step();
        chk("two_outst", 65'(resp_q.size()), 65'(2));
        br_valid = 1'b1; br_target = 32'h1c000100;
        step();
        rsp_pct = 100;
        wait_first("br_wait");
        chk("br_first", 65'(first_bus[31:0]), 65'(32'h1c000100));
        repeat (3) step();

        // Flush wins over branch in the same cycle.
        flush_valid = 1'b1; flush_target = 32'h1c008000;
        br_valid = 1'b1; br_target = 32'h1c000200;
        step();
        wait_first("prio_wait");
        chk("prio_first", 65'(first_bus[31:0]), 65'(32'h1c008000));
        repeat (3) step();

        // Misaligned target: one adef entry, then halted until the next redirect.
        br_valid = 1'b1; br_target = 32'h1c000102;
        step();
        wait_first("adef_wait");
        chk("adef_first", first_bus, {1'b1, 32'h0, 32'h1c000102});
        deliv_cnt = 0;
        repeat (6) step();
        chk("halt_no_req", 65'(last_req), 65'(0));
        chk("halt_no_entry", 65'(deliv_cnt), 65'(0));
        flush_valid = 1'b1; flush_target = 32'h1c008000;
        step();
        wait_first("unhalt_wait");
        chk("unhalt_first", 65'(first_bus[31:0]), 65'(32'h1c008000));

        // Randomized traffic with occasional redirects and one mid-run reset.
        ok_pct = 70; rsp_pct = 60; lat_max = 3;
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (n == 1500) do_reset();
            ds_allowin = ($urandom_range(99) < 70);
            r = $urandom_range(99);
            if (r < 3) begin
                br_valid  = 1'b1;
                br_target = {16'h1c00, 16'($urandom_range(65535))};
                if ($urandom_range(7) != 0) br_target[1:0] = 2'b00;
                if (r == 0) begin
                    flush_valid  = 1'b1;
                    flush_target = {16'h1c01, 16'($urandom_range(16383)) << 2};
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
